// File: rtl/atm_pkg.sv
// atm_pkg: shared state, error and service encodings for the ATM session controller.
package atm_pkg;
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LANG     = 4'd1,
    S_PIN      = 4'd2,
    S_SERVICE  = 4'd3,
    S_DEPOSIT  = 4'd4,
    S_WITHDRAW = 4'd5,
    S_BALANCE  = 4'd6,
    S_ANOTHER  = 4'd7
  } state_t;
  typedef enum logic [2:0] {
    E_NONE   = 3'd0,
    E_BADPIN = 3'd1,
    E_INSUF  = 3'd2,
    E_LIMIT  = 3'd3,
    E_OVF    = 3'd4,
    E_TMO    = 3'd5,
    E_LOCKED = 3'd6
  } err_t;
  localparam logic [1:0] SVC_DEP = 2'd1;
  localparam logic [1:0] SVC_WD  = 2'd2;
  localparam logic [1:0] SVC_BAL = 2'd3;
endpackage

// File: rtl/atm_inactivity_timer.sv
// atm_inactivity_timer: counts idle enabled cycles; o_expire fires on the edge the count would reach TIMEOUT_CYC.
module atm_inactivity_timer #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] r_cnt;
  assign o_expire = i_en && !i_clr && (r_cnt == W'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr || !i_en || o_expire) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: card/language/PIN/service session FSM with retry lockout,
// withdrawal limit, deposit overflow guard, inactivity abort and balance write-back strobe.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int BAL_W       = 16,
  parameter int AMT_W       = 8,
  parameter int PIN_W       = 16,
  parameter int CARD_W      = 16,
  parameter int NUM_LANG    = 2,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 15,
  parameter int WD_LIMIT    = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              card_present,
  input  logic [CARD_W-1:0] card_no,
  input  logic              lang_valid,
  input  logic [1:0]        lang,
  input  logic              pin_valid,
  input  logic [PIN_W-1:0]  pin,
  input  logic [PIN_W-1:0]  correct_pin,
  input  logic              svc_valid,
  input  logic [1:0]        svc,
  input  logic              amt_valid,
  input  logic [AMT_W-1:0]  amount,
  input  logic              another_valid,
  input  logic              another,
  input  logic [BAL_W-1:0]  bal_in,
  output logic [3:0]        state_o,
  output logic [BAL_W-1:0]  balance,
  output logic              bal_wr_en,
  output logic [2:0]        err_code,
  output logic              card_retained,
  output logic              timeout,
  output logic              session_end
);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  state_t r_state, w_state;
  err_t r_err, w_err;
  logic [BAL_W-1:0] r_bal, w_bal;
  logic [BAL_W:0] r_wd, w_wd, w_sum, w_wd_sum;
  logic [TRY_W-1:0] r_tries, w_tries;
  logic r_wr, w_wr, r_ret, w_ret, r_tmo, w_tmo, r_end, w_end;
  logic w_lang_ok, w_accept, w_removed, w_clr, w_expire;
  assign w_sum     = {1'b0, r_bal} + (BAL_W+1)'(amount);
  assign w_wd_sum  = r_wd + (BAL_W+1)'(amount);
  assign w_lang_ok = (lang != 2'd0) && (int'({30'd0, lang}) <= NUM_LANG);
  assign w_removed = (r_state != S_IDLE) && !card_present;
  // Strobes are only "accepted" in their own state; ignored codes/zero amounts do not count.
  assign w_accept  = (r_state == S_LANG && lang_valid && w_lang_ok)
                  || (r_state == S_PIN && pin_valid)
                  || (r_state == S_SERVICE && svc_valid && svc != 2'd0)
                  || ((r_state == S_DEPOSIT || r_state == S_WITHDRAW) && amt_valid && amount != '0)
                  || (r_state == S_ANOTHER && another_valid);
  assign w_clr     = w_accept || w_removed || r_state == S_BALANCE;
  atm_inactivity_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_clr),
    .i_en     (r_state != S_IDLE),
    .o_expire (w_expire)
  );
  always_comb begin
    w_state = r_state;
    w_err   = r_err;
    w_bal   = r_bal;
    w_wd    = r_wd;
    w_tries = r_tries;
    w_wr    = 1'b0;
    w_ret   = 1'b0;
    w_tmo   = 1'b0;
    w_end   = 1'b0;
    case (r_state)
      S_IDLE: if (card_present && card_no != '0) begin
        w_state = S_LANG;
        w_bal   = bal_in;
        w_tries = '0;
        w_wd    = '0;
        w_err   = E_NONE;
      end
      S_LANG: if (w_accept) begin
        w_state = S_PIN;
        w_err   = E_NONE;
      end
      S_PIN: if (w_accept) begin
        w_tries = (pin == correct_pin) ? '0 : r_tries + 1'b1;
        w_state = (pin == correct_pin) ? S_SERVICE : (r_tries == TRY_W'(MAX_TRIES - 1)) ? S_IDLE : S_PIN;
        w_err   = (pin == correct_pin) ? E_NONE : (r_tries == TRY_W'(MAX_TRIES - 1)) ? E_LOCKED : E_BADPIN;
        w_ret   = (pin != correct_pin) && (r_tries == TRY_W'(MAX_TRIES - 1));
      end
      S_SERVICE: if (w_accept) begin
        w_state = (svc == SVC_DEP) ? S_DEPOSIT : (svc == SVC_WD) ? S_WITHDRAW : S_BALANCE;
        w_err   = E_NONE;
      end
      S_DEPOSIT: if (w_accept) begin
        w_state = S_ANOTHER;
        w_err   = w_sum[BAL_W] ? E_OVF : E_NONE;
        w_bal   = w_sum[BAL_W] ? r_bal : w_sum[BAL_W-1:0];
        w_wr    = !w_sum[BAL_W];
      end
      S_WITHDRAW: if (w_accept) begin
        w_state = S_ANOTHER;
        w_err   = (BAL_W'(amount) > r_bal) ? E_INSUF : (w_wd_sum > (BAL_W+1)'(WD_LIMIT)) ? E_LIMIT : E_NONE;
        w_wr    = (BAL_W'(amount) <= r_bal) && (w_wd_sum <= (BAL_W+1)'(WD_LIMIT));
        w_bal   = w_wr ? r_bal - BAL_W'(amount) : r_bal;
        w_wd    = w_wr ? w_wd_sum : r_wd;
      end
      S_BALANCE: w_state = S_ANOTHER;
      S_ANOTHER: if (w_accept) begin
        w_state = another ? S_SERVICE : S_IDLE;
        w_end   = !another;
        w_err   = E_NONE;
      end
      default: w_state = S_IDLE;
    endcase
    if (w_expire) begin
      w_state = S_IDLE;
      w_tmo   = 1'b1;
      w_err   = E_TMO;
    end
    if (w_removed) begin
      w_state = S_IDLE;
      w_err   = E_TMO;
      w_bal   = r_bal;
      w_wd    = r_wd;
      w_tries = r_tries;
      w_wr    = 1'b0;
      w_ret   = 1'b0;
      w_tmo   = 1'b0;
      w_end   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_err   <= E_NONE;
      r_bal   <= '0;
      r_wd    <= '0;
      r_tries <= '0;
      r_wr    <= 1'b0;
      r_ret   <= 1'b0;
      r_tmo   <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_err   <= w_err;
      r_bal   <= w_bal;
      r_wd    <= w_wd;
      r_tries <= w_tries;
      r_wr    <= w_wr;
      r_ret   <= w_ret;
      r_tmo   <= w_tmo;
      r_end   <= w_end;
    end
  end
  assign state_o       = r_state;
  assign err_code      = r_err;
  assign balance       = r_bal;
  assign bal_wr_en     = r_wr;
  assign card_retained = r_ret;
  assign timeout       = r_tmo;
  assign session_end   = r_end;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: directed session scenarios; expectations queued per step and checked after each edge.
module tb_atm_session_ctrl;
  localparam logic [15:0] GOOD_PIN = 16'h4321;
  localparam int O_ST = 0, O_BAL = 1, O_ERR = 2, O_WR = 3, O_RET = 4, O_TMO = 5, O_END = 6;
  localparam int O_BAL8 = 7, O_ERR8 = 8, O_WR8 = 9, O_ST8 = 10;
  localparam int K_SVC = 1, K_AMT = 2, K_ANO = 3;
  logic clk = 1'b0, rst_n = 1'b0, card_present = 1'b0;
  logic [15:0] card_no = '0, pin = '0, correct_pin = GOOD_PIN, bal_in = '0;
  logic lang_valid = 1'b0, pin_valid = 1'b0, svc_valid = 1'b0, amt_valid = 1'b0;
  logic another_valid = 1'b0, another = 1'b0;
  logic [1:0] lang = '0, svc = '0;
  logic [7:0] amount = '0;
  logic [3:0] state_o, state8;
  logic [15:0] balance;
  logic [7:0] balance8;
  logic [2:0] err_code, err8;
  logic bal_wr_en, card_retained, timeout, session_end;
  logic wr8, ret8, tmo8, end8;
  int n_pass = 0, n_tot = 0;
  int q_sel[$];
  logic [31:0] q_val[$];
  string q_tag[$];

  always #5 clk = ~clk;

  atm_session_ctrl #(.BAL_W(16), .AMT_W(8), .PIN_W(16), .CARD_W(16), .NUM_LANG(2),
                     .MAX_TRIES(3), .TIMEOUT_CYC(15), .WD_LIMIT(200)) u_dut (
    .clk(clk), .rst_n(rst_n), .card_present(card_present), .card_no(card_no),
    .lang_valid(lang_valid), .lang(lang), .pin_valid(pin_valid), .pin(pin),
    .correct_pin(correct_pin), .svc_valid(svc_valid), .svc(svc), .amt_valid(amt_valid),
    .amount(amount), .another_valid(another_valid), .another(another), .bal_in(bal_in),
    .state_o(state_o), .balance(balance), .bal_wr_en(bal_wr_en), .err_code(err_code),
    .card_retained(card_retained), .timeout(timeout), .session_end(session_end));

  atm_session_ctrl #(.BAL_W(8), .AMT_W(8), .PIN_W(16), .CARD_W(16), .NUM_LANG(2),
                     .MAX_TRIES(3), .TIMEOUT_CYC(15), .WD_LIMIT(200)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .card_present(card_present), .card_no(card_no),
    .lang_valid(lang_valid), .lang(lang), .pin_valid(pin_valid), .pin(pin),
    .correct_pin(correct_pin), .svc_valid(svc_valid), .svc(svc), .amt_valid(amt_valid),
    .amount(amount), .another_valid(another_valid), .another(another), .bal_in(bal_in[7:0]),
    .state_o(state8), .balance(balance8), .bal_wr_en(wr8), .err_code(err8),
    .card_retained(ret8), .timeout(tmo8), .session_end(end8));

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      O_ST:    return 32'(state_o);
      O_BAL:   return 32'(balance);
      O_ERR:   return 32'(err_code);
      O_WR:    return 32'(bal_wr_en);
      O_RET:   return 32'(card_retained);
      O_TMO:   return 32'(timeout);
      O_END:   return 32'(session_end);
      O_BAL8:  return 32'(balance8);
      O_ERR8:  return 32'(err8);
      O_WR8:   return 32'(wr8);
      default: return 32'(state8);
    endcase
  endfunction

  task automatic exp(input int sel, input logic [31:0] val, input string tag);
    q_sel.push_back(sel);
    q_val.push_back(val);
    q_tag.push_back(tag);
  endtask

  task automatic tick();
    int s;
    logic [31:0] v, o;
    string t;
    @(posedge clk);
    #1;
    while (q_sel.size() > 0) begin
      s = q_sel.pop_front();
      v = q_val.pop_front();
      t = q_tag.pop_front();
      o = obs(s);
      n_tot++;
      assert (o === v) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", t, o, v);
    end
  endtask

  task automatic op(input int kind, input logic [7:0] v);
    svc_valid = (kind == K_SVC);
    amt_valid = (kind == K_AMT);
    another_valid = (kind == K_ANO);
    svc = v[1:0];
    amount = v;
    another = v[0];
    tick();
    svc_valid = 1'b0;
    amt_valid = 1'b0;
    another_valid = 1'b0;
  endtask

  task automatic start(input logic [15:0] c, input logic [15:0] b);
    card_present = 1'b1;
    card_no = c;
    bal_in = b;
    exp(O_ST, 1, "insert_state");
    exp(O_BAL, 32'(b), "insert_balance");
    tick();
    lang_valid = 1'b1;
    lang = 2'd1;
    exp(O_ST, 2, "lang_state");
    tick();
    lang_valid = 1'b0;
    pin_valid = 1'b1;
    pin = GOOD_PIN;
    exp(O_ST, 3, "pin_ok_state");
    tick();
    pin_valid = 1'b0;
  endtask

  task automatic finish_session();
    exp(O_ST, 0, "finish_state");
    exp(O_END, 1, "finish_end_pulse");
    op(K_ANO, 8'd0);
    card_present = 1'b0;
    exp(O_END, 0, "end_pulse_clears");
    tick();
  endtask

  initial begin
    exp(O_ST, 0, "rst_state");
    exp(O_BAL, 0, "rst_balance");
    exp(O_ERR, 0, "rst_err");
    exp(O_WR, 0, "rst_wr");
    exp(O_RET, 0, "rst_ret");
    exp(O_TMO, 0, "rst_tmo");
    exp(O_END, 0, "rst_end");
    exp(O_ST8, 0, "rst_state8");
    tick();
    rst_n = 1'b1;
    // Deposit session
    start(16'h1234, 16'd100);
    exp(O_ST, 4, "svc_deposit");
    op(K_SVC, 8'd1);
    exp(O_ST, 7, "dep_state");
    exp(O_BAL, 150, "dep_balance");
    exp(O_WR, 1, "dep_wr");
    exp(O_ERR, 0, "dep_err");
    op(K_AMT, 8'd50);
    exp(O_WR, 0, "dep_wr_one_cycle");
    exp(O_ST, 7, "another_wait");
    tick();
    finish_session();
    exp(O_BAL, 150, "bal_after_end");
    tick();
    // PIN lockout, with invalid language codes ignored first
    card_present = 1'b1;
    card_no = 16'h0055;
    bal_in = 16'd10;
    exp(O_ST, 1, "lock_insert");
    tick();
    lang_valid = 1'b1;
    lang = 2'd3;
    exp(O_ST, 1, "lang3_ignored");
    exp(O_ERR, 0, "lang3_no_err");
    tick();
    lang = 2'd0;
    exp(O_ST, 1, "lang0_ignored");
    tick();
    lang = 2'd2;
    exp(O_ST, 2, "lang2_ok");
    tick();
    lang_valid = 1'b0;
    pin_valid = 1'b1;
    pin = 16'h1111;
    exp(O_ST, 2, "bad1_state");
    exp(O_ERR, 1, "bad1_err");
    tick();
    exp(O_ST, 2, "bad2_state");
    exp(O_ERR, 1, "bad2_err");
    exp(O_RET, 0, "bad2_no_ret");
    tick();
    exp(O_ST, 0, "locked_state");
    exp(O_ERR, 6, "locked_err");
    exp(O_RET, 1, "retain_pulse");
    tick();
    pin_valid = 1'b0;
    card_present = 1'b0;
    exp(O_RET, 0, "retain_one_cycle");
    exp(O_ERR, 6, "locked_err_sticky");
    tick();
    // Withdraw whole balance, then insufficient funds
    start(16'h0077, 16'd30);
    exp(O_ST, 5, "svc_withdraw");
    op(K_SVC, 8'd2);
    exp(O_BAL, 0, "wd_all_balance");
    exp(O_WR, 1, "wd_all_wr");
    exp(O_ERR, 0, "wd_all_err");
    op(K_AMT, 8'd30);
    exp(O_ST, 3, "another_yes");
    op(K_ANO, 8'd1);
    op(K_SVC, 8'd2);
    exp(O_ERR, 2, "insuf_err");
    exp(O_BAL, 0, "insuf_balance");
    exp(O_WR, 0, "insuf_no_wr");
    exp(O_ST, 7, "insuf_state");
    op(K_AMT, 8'd1);
    finish_session();
    // Per-session withdrawal limit
    start(16'h0088, 16'd500);
    op(K_SVC, 8'd2);
    exp(O_BAL, 350, "wd150_balance");
    exp(O_WR, 1, "wd150_wr");
    op(K_AMT, 8'd150);
    op(K_ANO, 8'd1);
    op(K_SVC, 8'd2);
    exp(O_ERR, 3, "limit_err");
    exp(O_BAL, 350, "limit_balance");
    exp(O_WR, 0, "limit_no_wr");
    op(K_AMT, 8'd60);
    op(K_ANO, 8'd1);
    op(K_SVC, 8'd2);
    exp(O_BAL, 300, "at_limit_balance");
    exp(O_WR, 1, "at_limit_wr");
    exp(O_ERR, 0, "at_limit_err");
    op(K_AMT, 8'd50);
    finish_session();
    // Deposit overflow on the 8-bit instance
    start(16'h0099, 16'd250);
    exp(O_ST8, 4, "ovf_svc_state8");
    op(K_SVC, 8'd1);
    exp(O_ERR8, 4, "ovf_err8");
    exp(O_BAL8, 250, "ovf_balance8");
    exp(O_WR8, 0, "ovf_no_wr8");
    exp(O_ST8, 7, "ovf_state8");
    exp(O_BAL, 260, "wide_no_ovf_balance");
    op(K_AMT, 8'd10);
    op(K_ANO, 8'd1);
    op(K_SVC, 8'd1);
    exp(O_BAL8, 255, "fill_max_balance8");
    exp(O_WR8, 1, "fill_max_wr8");
    exp(O_ERR8, 0, "fill_max_err8");
    op(K_AMT, 8'd5);
    finish_session();
    // Inactivity timeout in SERVICE
    start(16'h00AB, 16'd40);
    for (int i = 0; i < 13; i++) tick();
    exp(O_ST, 3, "stall14_state");
    exp(O_TMO, 0, "stall14_no_tmo");
    tick();
    exp(O_ST, 0, "tmo_state");
    exp(O_TMO, 1, "tmo_pulse");
    exp(O_ERR, 5, "tmo_err");
    tick();
    card_present = 1'b0;
    exp(O_TMO, 0, "tmo_one_cycle");
    exp(O_ST, 0, "tmo_idle");
    tick();
    // Strobe on the expiry edge wins
    start(16'h00AC, 16'd40);
    for (int i = 0; i < 14; i++) tick();
    exp(O_ST, 6, "edge_svc_state");
    exp(O_TMO, 0, "edge_no_tmo");
    op(K_SVC, 8'd3);
    exp(O_ST, 7, "balance_to_another");
    exp(O_WR, 0, "balance_no_wr");
    tick();
    finish_session();
    // Card removal beats a simultaneous amount strobe
    start(16'h00CD, 16'd70);
    op(K_SVC, 8'd1);
    card_present = 1'b0;
    exp(O_ST, 0, "removal_state");
    exp(O_ERR, 5, "removal_err");
    exp(O_WR, 0, "removal_no_wr");
    exp(O_BAL, 70, "removal_balance");
    op(K_AMT, 8'd20);
    // Reset mid-session
    start(16'h00EE, 16'd90);
    op(K_SVC, 8'd2);
    rst_n = 1'b0;
    exp(O_ST, 0, "midrst_state");
    exp(O_BAL, 0, "midrst_balance");
    exp(O_WR, 0, "midrst_no_wr");
    op(K_AMT, 8'd10);
    rst_n = 1'b1;
    card_present = 1'b0;
    exp(O_ST, 0, "post_rst_idle");
    tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
